imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, word-address width of instruction memory.
REQ-002 SHALL have parameter DW, default 32, instruction/data word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ld_req/ld_wr/ld_addr/ld_wdata  input  1/1/AW/DW  loader request, 1=write, address, write data.
REQ-006 SHALL have ports ld_gnt/ld_rvalid/ld_rdata  output  1/1/DW  loader grant, read-data valid, read data.
REQ-007 SHALL have port ld_done  input  1  single-cycle pulse, program image fully loaded.
REQ-008 SHALL have ports cpu_req/cpu_addr  input  1/AW  CPU fetch request and address; read only.
REQ-009 SHALL have ports cpu_gnt/cpu_rvalid/cpu_rdata/cpu_hold  output  1/1/DW/1  fetch grant, data valid, data, pipeline stall.
REQ-010 SHALL have ports mem_en/mem_rd_wr/mem_addr/mem_wdata  output  1/1/AW/DW  memory enable, 1=write, address, write data.
REQ-011 SHALL have port mem_rdata  input  DW  memory read data, valid one cycle after a read access.
REQ-012 SHALL have ports run/stall_cnt  output  1/16  boot complete flag, CPU stall cycle count.

Function
REQ-013 SHALL implement FSM states BOOT and RUN; BOOT -> RUN on the cycle after ld_done is sampled high in BOOT; RUN left only by rst.
REQ-014 In BOOT SHALL grant ld_req combinationally (ld_gnt=ld_req), hold cpu_gnt=0, cpu_hold=1, run=0.
REQ-015 In RUN SHALL drive run=1; ld_done ignored.
REQ-016 In RUN, single requester SHALL be granted in the same cycle.
REQ-017 In RUN with ld_req and cpu_req both high SHALL grant the loader unless the loader won the previous cycle (last_ld flag), then grant the CPU; no requester waits more than 1 cycle.
REQ-018 At most one of ld_gnt, cpu_gnt SHALL be high in any cycle.
REQ-019 cpu_hold SHALL equal ~run | (cpu_req & ~cpu_gnt).
REQ-020 mem_en SHALL equal ld_gnt | cpu_gnt; mem_addr/mem_wdata/mem_rd_wr SHALL come from the granted requester; CPU access forces mem_rd_wr=0; idle drives all mem_* to 0.
REQ-021 ld_rvalid SHALL be registered (ld_gnt & ~ld_wr); cpu_rvalid registered cpu_gnt; latency 1 cycle; rdata outputs = mem_rdata when matching rvalid high, else 0.
REQ-022 Loader write never asserts ld_rvalid.
REQ-023 ld_done and ld_req coincident in BOOT: request granted that cycle, transition next cycle.

Reset
REQ-024 rst SHALL force state BOOT, last_ld=0, all rvalid=0, stall_cnt=0, run=0, cpu_hold=1, all other outputs 0 (given idle inputs).
REQ-025 rst mid-access SHALL drop the pending rvalid; no rvalid in the cycle after rst.

Configuration
REQ-026 With IMEM_ARB_STALL_CNT_EN defined, stall_cnt SHALL increment each RUN cycle with cpu_req & ~cpu_gnt, saturating at 16'hFFFF.
REQ-027 Without IMEM_ARB_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic inferred.

Structure
REQ-028 Package imem_arb_pkg SHALL hold the FSM state enum, default AW/DW constants and STALL_CNT_W=16.
REQ-029 No sub-module; arbiter, FSM and counter in one module.

Verification
REQ-030 Boot load: ld writes addr 0..3 = 32'h1111_0000+i, cpu_req=1 throughout -> cpu_gnt=0, cpu_hold=1, run=0, four mem writes; ld_done -> run=1 next cycle.
REQ-031 Fetch: RUN, cpu_req addr 8'h02, mem_rdata 32'hDEAD_BEEF -> cpu_gnt same cycle, cpu_rvalid and cpu_rdata=32'hDEAD_BEEF next cycle.
REQ-032 Contention: RUN, ld_req (read) and cpu_req held high 6 cycles -> grants alternate L,C,L,C,L,C; stall_cnt=3 with macro, 0 without.
REQ-033 Reset mid-read: loader read granted, rst next cycle -> ld_rvalid=0, state BOOT, run=0.
REQ-034 Saturation (macro on): force 70000 stalled cycles -> stall_cnt=16'hFFFF, holds.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 32;
    localparam int STALL_CNT_W = 16;

endpackage : imem_arb_pkg

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: the loader owns the memory during boot, then
// the loader and CPU fetch port share one memory port with alternating
// priority on contention.
//
// Optional build macro IMEM_ARB_STALL_CNT_EN adds a saturating counter of
// CPU stall cycles in RUN; without it stall_cnt is tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | program image loading; loader owns memory, CPU held
// RUN   | normal operation; loader/CPU arbitrated, left only by rst
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_req,
    input  logic                   ld_wr,
    input  logic [AW-1:0]          ld_addr,
    input  logic [DW-1:0]          ld_wdata,
    output logic                   ld_gnt,
    output logic                   ld_rvalid,
    output logic [DW-1:0]          ld_rdata,
    input  logic                   ld_done,
    input  logic                   cpu_req,
    input  logic [AW-1:0]          cpu_addr,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   cpu_hold,
    output logic                   mem_en,
    output logic                   mem_rd_wr,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    output logic                   run,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    arb_state_e state_q, state_d;
    logic       last_ld_q, last_ld_d;
    logic       ld_rvalid_q, ld_rvalid_d;
    logic       cpu_rvalid_q, cpu_rvalid_d;

    // Next state, grant decision and memory-port steering.
    always_comb begin
        state_d   = state_q;
        ld_gnt    = 1'b0;
        cpu_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_rd_wr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (state_q == ST_BOOT) begin
            ld_gnt = ld_req;
            if (ld_done) begin
                state_d = ST_RUN;
            end
        end else if (ld_req && cpu_req) begin
            // Loader normally wins a tie, but never twice in a row.
            ld_gnt  = ~last_ld_q;
            cpu_gnt = last_ld_q;
        end else begin
            ld_gnt  = ld_req;
            cpu_gnt = cpu_req;
        end

        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_rd_wr = ld_wr;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = cpu_addr;
        end

        // Boot-time grants do not count toward the tie-break history.
        last_ld_d    = (state_q == ST_RUN) && ld_gnt;
        ld_rvalid_d  = ld_gnt && !ld_wr;
        cpu_rvalid_d = cpu_gnt;
    end

    // State, tie-break history and read-valid pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            last_ld_q    <= 1'b0;
            ld_rvalid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_ld_q    <= last_ld_d;
            ld_rvalid_q  <= ld_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign run        = (state_q == ST_RUN);
    assign cpu_hold   = ~run | (cpu_req & ~cpu_gnt);
    assign ld_rvalid  = ld_rvalid_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ld_rdata   = ld_rvalid_q  ? mem_rdata : '0;
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;

`ifdef IMEM_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of RUN cycles where the CPU asked but was refused.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (run && cpu_req && !cpu_gnt && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule : imem_arbiter
